filter: RTL and testbench

FILTER -- requirements
Module: filter

---
 rtl/filter.sv | 123 ++++++++++++
 tb/tb_filter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter.sv
// rtl/filter.sv - direct-form-I biquad IIR filter with saturating fixed-point output
module filter #(
    parameter int V_IN_WIDTH     = 18,
    parameter int V_IN_EXPONENT  = -16,
    parameter int V_OUT_WIDTH    = 18,
    parameter int V_OUT_EXPONENT = -14,
    parameter int COEF_FRAC      = 16,
    parameter int B0             = 4096,
    parameter int B1             = 0,
    parameter int B2             = 0,
    parameter int A1             = -98304,
    parameter int A2             = 36864,
    parameter int STATE_FRAC     = 24,
    parameter int STATE_WIDTH    = 40
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [V_IN_WIDTH-1:0]  v_in,
    output logic signed [V_OUT_WIDTH-1:0] v_out
);

    localparam int IN_SHIFT  = STATE_FRAC + V_IN_EXPONENT;
    localparam int IN_LSH    = (IN_SHIFT > 0) ? IN_SHIFT : 0;
    localparam int IN_RSH    = (IN_SHIFT < 0) ? -IN_SHIFT : 0;
    localparam int XW        = V_IN_WIDTH + IN_LSH;
    localparam int CW        = 32;
    localparam int OPW       = (XW > STATE_WIDTH) ? XW : STATE_WIDTH;
    // Five full-width products summed: 3 guard bits cover the additions.
    localparam int ACC_W     = OPW + CW + 3;
    localparam int OUT_SHIFT = STATE_FRAC + V_OUT_EXPONENT;
    localparam int OUT_RSH   = (OUT_SHIFT > 0) ? OUT_SHIFT : 0;
    localparam int OUT_LSH   = (OUT_SHIFT < 0) ? -OUT_SHIFT : 0;
    localparam int RW        = STATE_WIDTH + 1 + OUT_LSH;
    localparam int HALF_SH   = (OUT_RSH > 0) ? OUT_RSH - 1 : 0;

    localparam logic signed [CW-1:0] C_B0 = B0;
    localparam logic signed [CW-1:0] C_B1 = B1;
    localparam logic signed [CW-1:0] C_B2 = B2;
    localparam logic signed [CW-1:0] C_A1 = A1;
    localparam logic signed [CW-1:0] C_A2 = A2;

    localparam logic signed [ACC_W-1:0] Y_MAX =
        {{(ACC_W-STATE_WIDTH+1){1'b0}}, {(STATE_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN =
        {{(ACC_W-STATE_WIDTH+1){1'b1}}, {(STATE_WIDTH-1){1'b0}}};
    localparam logic signed [RW-1:0] O_MAX =
        {{(RW-V_OUT_WIDTH+1){1'b0}}, {(V_OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] O_MIN =
        {{(RW-V_OUT_WIDTH+1){1'b1}}, {(V_OUT_WIDTH-1){1'b0}}};
    localparam logic signed [RW-1:0] HALF = (OUT_RSH > 0) ? (RW'(1) << HALF_SH) : '0;

    logic signed [V_IN_WIDTH-1:0]  r_x1;
    logic signed [V_IN_WIDTH-1:0]  r_x2;
    logic signed [STATE_WIDTH-1:0] r_y1;
    logic signed [STATE_WIDTH-1:0] r_y2;
    logic signed [V_OUT_WIDTH-1:0] r_v_out;

    logic signed [XW-1:0]          w_x0;
    logic signed [XW-1:0]          w_x1;
    logic signed [XW-1:0]          w_x2;
    logic signed [ACC_W-1:0]       w_acc;
    logic signed [ACC_W-1:0]       w_y_full;
    logic signed [STATE_WIDTH-1:0] w_y_sat;
    logic signed [RW-1:0]          w_round;
    logic signed [V_OUT_WIDTH-1:0] w_out_sat;

    // History keeps the raw sample; alignment to the state grid is recomputed per tap.
    function automatic logic signed [XW-1:0] align(input logic signed [V_IN_WIDTH-1:0] v);
        align = (XW'(v) <<< IN_LSH) >>> IN_RSH;
    endfunction

    assign w_x0 = align(v_in);
    assign w_x1 = align(r_x1);
    assign w_x2 = align(r_x2);

    assign w_acc = ACC_W'(w_x0) * ACC_W'(C_B0)
                 + ACC_W'(w_x1) * ACC_W'(C_B1)
                 + ACC_W'(w_x2) * ACC_W'(C_B2)
                 - ACC_W'(r_y1) * ACC_W'(C_A1)
                 - ACC_W'(r_y2) * ACC_W'(C_A2);

    assign w_y_full = w_acc >>> COEF_FRAC;

    always_comb begin
        w_y_sat = w_y_full[STATE_WIDTH-1:0];
        if (w_y_full > Y_MAX) begin
            w_y_sat = Y_MAX[STATE_WIDTH-1:0];
        end else if (w_y_full < Y_MIN) begin
            w_y_sat = Y_MIN[STATE_WIDTH-1:0];
        end
    end

    // Round half up onto the output grid, then clamp to the output rails.
    assign w_round = ((RW'(w_y_sat) <<< OUT_LSH) + HALF) >>> OUT_RSH;

    always_comb begin
        w_out_sat = w_round[V_OUT_WIDTH-1:0];
        if (w_round > O_MAX) begin
            w_out_sat = O_MAX[V_OUT_WIDTH-1:0];
        end else if (w_round < O_MIN) begin
            w_out_sat = O_MIN[V_OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_x1    <= '0;
            r_x2    <= '0;
            r_y1    <= '0;
            r_y2    <= '0;
            r_v_out <= '0;
        end else begin
            r_x1    <= v_in;
            r_x2    <= r_x1;
            r_y1    <= w_y_sat;
            r_y2    <= r_y1;
            r_v_out <= w_out_sat;
        end
    end

    assign v_out = r_v_out;

endmodule

// File: tb/tb_filter.sv
// tb/tb_filter.sv - scoreboard bench for the biquad filter
module tb_filter;

    logic               clk;
    logic               rst;
    logic signed [17:0] v_in_a;
    logic signed [17:0] v_in_b;
    logic signed [17:0] v_out_a;
    logic signed [17:0] v_out_b;

    int total = 0;
    int bad   = 0;

    localparam longint MB1   = 0;
    localparam longint MB2   = 0;
    localparam longint MA1   = -98304;
    localparam longint MA2   = 36864;
    localparam longint B0_A  = 4096;
    localparam longint B0_B  = 393216;
    localparam longint Y_HI  = (longint'(1) <<< 39) - 1;
    localparam longint Y_LO  = -(longint'(1) <<< 39);

    longint m_x1, m_x2, m_y1, m_y2;
    logic signed [17:0] exp_q[$];

    filter u_dut_a (
        .clk  (clk),
        .rst  (rst),
        .v_in (v_in_a),
        .v_out(v_out_a)
    );

    filter #(.B0(393216)) u_dut_b (
        .clk  (clk),
        .rst  (rst),
        .v_in (v_in_b),
        .v_out(v_out_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_clear();
        m_x1 = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic signed [17:0] v, input longint b0,
                              output logic signed [17:0] o);
        longint acc, y, r;
        acc = b0 * (longint'(v) * 256) + MB1 * (m_x1 * 256) + MB2 * (m_x2 * 256)
            - MA1 * m_y1 - MA2 * m_y2;
        y = acc >>> 16;
        if (y > Y_HI) y = Y_HI;
        else if (y < Y_LO) y = Y_LO;
        r = (y + 512) >>> 10;
        if (r > 131071) r = 131071;
        else if (r < -131072) r = -131072;
        m_x2 = m_x1; m_x1 = longint'(v);
        m_y2 = m_y1; m_y1 = y;
        o = r[17:0];
    endtask

    // Drive one sample to both DUTs, push the expectation for the selected one.
    task automatic drive_edge(input logic signed [17:0] va, input logic signed [17:0] vb,
                              input int which);
        logic signed [17:0] e;
        v_in_a = va;
        v_in_b = vb;
        if (which == 0) model_step(va, B0_A, e);
        else            model_step(vb, B0_B, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
        model_clear();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        v_in_a = 18'sd65536;
        v_in_b = 18'sd65536;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (v_out_a !== 18'sd0 || v_out_b !== 18'sd0) begin
                bad++;
                $display("FAIL reset cyc=%0d a=%0d b=%0d want 0", i, v_out_a, v_out_b);
            end
        end
        model_clear();
    endtask

    task automatic test_step();
        logic signed [17:0] e, prev;
        logic signed [17:0] first3 [3];
        first3[0] = 18'sd1024; first3[1] = 18'sd2560; first3[2] = 18'sd4288;
        prev = 18'sd0;
        rst = 1'b1;
        for (int i = 0; i < 200; i++) begin
            drive_edge(18'sd65536, 18'sd0, 0);
            e = exp_q.pop_front();
            total++;
            if (v_out_a !== e) begin
                bad++;
                $display("FAIL step_model cyc=%0d got=%0d want=%0d", i, v_out_a, e);
            end
            if (i < 3) begin
                total++;
                if (v_out_a !== first3[i]) begin
                    bad++;
                    $display("FAIL step_start cyc=%0d got=%0d want=%0d", i, v_out_a, first3[i]);
                end
            end
            total++;
            if (v_out_a < prev || v_out_a > 18'sd16384) begin
                bad++;
                $display("FAIL step_monotonic cyc=%0d got=%0d prev=%0d max=16384", i, v_out_a, prev);
            end
            prev = v_out_a;
        end
        total++;
        if (v_out_a < 18'sd16383 || v_out_a > 18'sd16384) begin
            bad++;
            $display("FAIL step_settle got=%0d want 16383..16384", v_out_a);
        end
    endtask

    task automatic test_mid_reset();
        logic signed [17:0] e;
        apply_reset(2);
        for (int i = 0; i < 50; i++) begin
            drive_edge(18'sd65536, 18'sd0, 0);
            e = exp_q.pop_front();
            total++;
            if (v_out_a !== e) begin
                bad++;
                $display("FAIL midrst_run cyc=%0d got=%0d want=%0d", i, v_out_a, e);
            end
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (v_out_a !== 18'sd0) begin
            bad++;
            $display("FAIL midrst_clear got=%0d want=0", v_out_a);
        end
        model_clear();
        rst = 1'b1;
        drive_edge(18'sd65536, 18'sd0, 0);
        e = exp_q.pop_front();
        total++;
        if (v_out_a !== 18'sd1024 || v_out_a !== e) begin
            bad++;
            $display("FAIL midrst_restart got=%0d want=1024 model=%0d", v_out_a, e);
        end
    endtask

    task automatic test_zero();
        logic signed [17:0] e;
        apply_reset(2);
        for (int i = 0; i < 30; i++) begin
            drive_edge(18'sd0, 18'sd0, 0);
            e = exp_q.pop_front();
            total++;
            if (v_out_a !== 18'sd0 || v_out_a !== e) begin
                bad++;
                $display("FAIL zero cyc=%0d got=%0d want=0", i, v_out_a);
            end
        end
    endtask

    task automatic test_impulse();
        logic signed [17:0] e;
        logic signed [17:0] head [3];
        head[0] = 18'sd1024; head[1] = 18'sd1536; head[2] = 18'sd1728;
        apply_reset(2);
        for (int i = 0; i < 80; i++) begin
            drive_edge((i == 0) ? 18'sd65536 : 18'sd0, 18'sd0, 0);
            e = exp_q.pop_front();
            total++;
            if (v_out_a !== e) begin
                bad++;
                $display("FAIL impulse_model cyc=%0d got=%0d want=%0d", i, v_out_a, e);
            end
            if (i < 3) begin
                total++;
                if (v_out_a !== head[i]) begin
                    bad++;
                    $display("FAIL impulse_head cyc=%0d got=%0d want=%0d", i, v_out_a, head[i]);
                end
            end
        end
        total++;
        if (v_out_a !== 18'sd0) begin
            bad++;
            $display("FAIL impulse_decay got=%0d want=0", v_out_a);
        end
    endtask

    task automatic test_overflow();
        logic signed [17:0] e;
        apply_reset(2);
        for (int i = 0; i < 100; i++) begin
            drive_edge(18'sd0, 18'sd65536, 1);
            e = exp_q.pop_front();
            total++;
            if (v_out_b !== e || v_out_b < 18'sd0) begin
                bad++;
                $display("FAIL ovf_pos cyc=%0d got=%0d want=%0d", i, v_out_b, e);
            end
        end
        total++;
        if (v_out_b !== 18'sd131071) begin
            bad++;
            $display("FAIL ovf_pos_rail got=%0d want=131071", v_out_b);
        end
        apply_reset(2);
        for (int i = 0; i < 100; i++) begin
            drive_edge(18'sd0, -18'sd65536, 1);
            e = exp_q.pop_front();
            total++;
            if (v_out_b !== e || v_out_b > 18'sd0) begin
                bad++;
                $display("FAIL ovf_neg cyc=%0d got=%0d want=%0d", i, v_out_b, e);
            end
        end
        total++;
        if (v_out_b !== -18'sd131072) begin
            bad++;
            $display("FAIL ovf_neg_rail got=%0d want=-131072", v_out_b);
        end
    endtask

    task automatic test_random();
        logic signed [17:0] e, v;
        apply_reset(2);
        for (int i = 0; i < 10000; i++) begin
            v = 18'($urandom_range(262143, 0));
            drive_edge(v, 18'sd0, 0);
            e = exp_q.pop_front();
            total++;
            if (v_out_a !== e) begin
                bad++;
                $display("FAIL random cyc=%0d in=%0d got=%0d want=%0d", i, v, v_out_a, e);
            end
        end
    endtask

    initial begin
        rst    = 1'b0;
        v_in_a = 18'sd0;
        v_in_b = 18'sd0;
        model_clear();
        test_reset();
        test_step();
        test_mid_reset();
        test_zero();
        test_impulse();
        test_overflow();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
